// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of one shared combinational ALU.
// Latency: handshake in cycle T -> rspN_valid in T+2; one operation per 3 cycles at best.
// Backpressure: reqN_ready only in IDLE; RESP holds all data stable until the owner's rsp_ready.
// Ports: req0/req1 valid-ready operation channels, alu_* registered drive to the ALU,
//        alu_result/alu_zero combinational ALU return, rsp0/rsp1 valid-ready responses
//        sharing rsp_result/rsp_zero, busy = FSM not idle.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins);
//               when undefined, arbitration is round-robin on a last_grant register.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [2:0]       req0_alucontrol,
    input  logic [2:0]       req1_alucontrol,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_alucontrol,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   owner;      // requester that owns the in-flight operation
    logic   win0;
    logic   win1;
    logic   accept;
    logic   sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win0 = req0_valid;
    assign win1 = req1_valid & ~req0_valid;
`else
    logic last_grant;   // id of the most recent winner; the other side wins a tie

    assign win0 = req0_valid & (~req1_valid | last_grant);
    assign win1 = req1_valid & (~req0_valid | ~last_grant);
`endif

    // Readies are combinational so a requester is accepted in the same cycle it asks.
    assign req0_ready = (state == IDLE) & win0;
    assign req1_ready = (state == IDLE) & win1;
    assign accept     = req0_ready | req1_ready;
    assign sel        = req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= 1'b0;
            alu_srca       <= '0;
            alu_srcb       <= '0;
            alu_alucontrol <= '0;
            rsp_result     <= '0;
            rsp_zero       <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            busy           <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Opcode is forwarded untouched; the arbiter never decodes it.
                        alu_srca       <= sel ? req1_srca : req0_srca;
                        alu_srcb       <= sel ? req1_srcb : req0_srcb;
                        alu_alucontrol <= sel ? req1_alucontrol : req0_alucontrol;
                        owner          <= sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant     <= sel;
`endif
                        busy           <= 1'b1;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp0_valid <= ~owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    // Only the owner's valid is high, so a non-owner ready cannot match.
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural shared ALU.
// Inputs change just after the rising edge, outputs are sampled on the falling edge.
// Expected responses are queued at request acceptance and popped when a response appears.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [2:0]   req0_alucontrol, req1_alucontrol;
    logic [W-1:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]   alu_alucontrol;
    logic         alu_zero;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, busy;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb),
        .req0_alucontrol(req0_alucontrol), .req1_alucontrol(req1_alucontrol),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_alucontrol(alu_alucontrol),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    function automatic exp_t mk(input logic id, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        r.id   = id;
        r.res  = alu_fn(c, a, b);
        r.zero = (r.res == '0);
        return r;
    endfunction

    // Shared ALU model driven by the arbiter's registered outputs.
    assign alu_result = alu_fn(alu_alucontrol, alu_srca, alu_srcb);
    assign alu_zero   = (alu_result == '0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid = 0; req1_valid = 0;
        req0_srca = '0; req0_srcb = '0; req1_srca = '0; req1_srcb = '0;
        req0_alucontrol = '0; req1_alucontrol = '0;
    endtask

    task automatic drive_req(input logic id, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_valid = 1; req1_alucontrol = c; req1_srca = a; req1_srcb = b;
        end else begin
            req0_valid = 1; req0_alucontrol = c; req0_srca = a; req0_srcb = b;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        clear_reqs();
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // Waits (bounded) for any response valid; leaves the caller on a falling edge.
    task automatic wait_rsp(output bit got);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                got = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({alu_srca, alu_srcb, alu_alucontrol, rsp_result, rsp_zero, rsp0_valid, rsp1_valid,
             busy, req0_ready, req1_ready} !== '0)
            $display("FAIL reset_outputs: alu_srca=%0h alu_srcb=%0h ctl=%0b rsp=%0h z=%0b v0=%0b v1=%0b busy=%0b rdy=%0b%0b, want all 0",
                     alu_srca, alu_srcb, alu_alucontrol, rsp_result, rsp_zero, rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int t0;
        tick();
        drive_req(0, 3'b001, 5, 3);
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL basic_ready: got %b want 10", {req0_ready, req1_ready});
        else n_pass++;
        sb.push_back(mk(0, 3'b001, 5, 3));
        t0 = cyc;
        tick();
        req0_valid = 0;
        @(negedge clk);
        n_checks++;
        if ({busy, rsp0_valid, rsp1_valid, alu_srca, alu_srcb, alu_alucontrol} !== {1'b1, 2'b00, W'(5), W'(3), 3'b001})
            $display("FAIL basic_exec: busy=%0b v=%0b%0b alu=%0h,%0h,%0b want busy=1 v=00 alu=5,3,001",
                     busy, rsp0_valid, rsp1_valid, alu_srca, alu_srcb, alu_alucontrol);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b10 || cyc - t0 != 2)
            $display("FAIL basic_latency: v=%b after %0d cycles want v=10 after 2", {rsp0_valid, rsp1_valid}, cyc - t0);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (rsp_result !== e.res || rsp_zero !== e.zero)
            $display("FAIL basic_result: got %0h z=%0b want %0h z=%0b", rsp_result, rsp_zero, e.res, e.zero);
        else n_pass++;
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        @(negedge clk);
        n_checks++;
        if ({busy, rsp0_valid} !== 2'b00) $display("FAIL basic_idle: busy=%0b v0=%0b want 0 0", busy, rsp0_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int   grants = 0;
        int   last_hs = 0;
        logic exp_w;
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        drive_req(0, 3'b000, 10, 20);
        drive_req(1, 3'b100, 32'hF0, 32'h0F);
        for (int c = 0; c < 40 && !(grants == 4 && sb.size() == 0); c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                exp_w = 1'b0;
`else
                exp_w = (grants % 2) != 0;
`endif
                n_checks++;
                if ({req0_ready, req1_ready} !== (exp_w ? 2'b01 : 2'b10))
                    $display("FAIL rr_grant%0d: ready=%b want %b", grants, {req0_ready, req1_ready}, exp_w ? 2'b01 : 2'b10);
                else n_pass++;
                if (grants > 0) begin
                    n_checks++;
                    if (cyc - last_hs != 3) $display("FAIL rr_spacing%0d: got %0d cycles want 3", grants, cyc - last_hs);
                    else n_pass++;
                end
                last_hs = cyc;
                sb.push_back(req1_ready ? mk(1, 3'b100, 32'hF0, 32'h0F) : mk(0, 3'b000, 10, 20));
                grants++;
            end
            if (rsp0_valid || rsp1_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rr_unexpected_rsp: v=%b want no response", {rsp0_valid, rsp1_valid});
                end else begin
                    e = sb.pop_front();
                    if ({rsp0_valid, rsp1_valid, rsp_result} !== {~e.id, e.id, e.res})
                        $display("FAIL rr_rsp: v=%b res=%0h want v=%b res=%0h", {rsp0_valid, rsp1_valid}, rsp_result, {~e.id, e.id}, e.res);
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
            if (grants == 4) begin
                req0_valid = 0; req1_valid = 0;
            end
        end
        n_checks++;
        if (grants != 4 || sb.size() != 0) $display("FAIL rr_complete: grants=%0d pending=%0d want 4 and 0", grants, sb.size());
        else n_pass++;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_stall();
        bit got;
        int bad = 0;
        tick();
        drive_req(1, 3'b010, 7, 7);
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL stall_ready: got %b want 01", {req0_ready, req1_ready});
        else n_pass++;
        sb.push_back(mk(1, 3'b010, 7, 7));
        tick();
        req1_valid = 0;
        drive_req(0, 3'b000, 1, 1);
        wait_rsp(got);
        n_checks++;
        if (!got) $display("FAIL stall_rsp_timeout: got none want rsp1_valid");
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            if ({rsp1_valid, rsp0_valid, req0_ready, busy} !== 4'b1001 || rsp_result !== W'(7) || alu_srca !== W'(7)) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) $display("FAIL stall_hold: %0d unstable cycles want 0 (v1=%0b v0=%0b rdy0=%0b res=%0h)",
                               bad, rsp1_valid, rsp0_valid, req0_ready, rsp_result);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (rsp_result !== e.res || rsp_zero !== e.zero) $display("FAIL stall_result: got %0h want %0h", rsp_result, e.res);
        else n_pass++;
        req0_valid = 0;
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        @(negedge clk);
        n_checks++;
        if ({busy, rsp1_valid} !== 2'b00) $display("FAIL stall_release: busy=%0b v1=%0b want 0 0", busy, rsp1_valid);
        else n_pass++;
    endtask

    task automatic test_reset_in_resp();
        bit got;
        int seen = 0;
        tick();
        drive_req(0, 3'b000, 1, 1);
        @(negedge clk);
        sb.push_back(mk(0, 3'b000, 1, 1));
        tick();
        req0_valid = 0;
        wait_rsp(got);
        n_checks++;
        if (!got || rsp0_valid !== 1'b1) $display("FAIL rir_reach_resp: v0=%0b want 1", rsp0_valid);
        else n_pass++;
        sb.delete();
        tick();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        n_checks++;
        if ({rsp0_valid, rsp1_valid, busy, rsp_result, rsp_zero, alu_srca, alu_srcb} !== '0)
            $display("FAIL rir_cleared: v=%b busy=%0b res=%0h alu=%0h,%0h want all 0",
                     {rsp0_valid, rsp1_valid}, busy, rsp_result, alu_srca, alu_srcb);
        else n_pass++;
        rsp0_ready = 1;
        repeat (3) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) seen++;
        end
        rsp0_ready = 0;
        n_checks++;
        if (seen != 0) $display("FAIL rir_no_rsp: %0d cycles with activity want 0", seen);
        else n_pass++;
    endtask

    task automatic test_nonowner_ready();
        bit got;
        int stuck = 0;
        tick();
        rsp1_ready = 1;
        drive_req(0, 3'b001, 4, 4);
        @(negedge clk);
        sb.push_back(mk(0, 3'b001, 4, 4));
        tick();
        req0_valid = 0;
        wait_rsp(got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp0_valid !== 1'b1 || rsp_zero !== e.zero || rsp_result !== e.res)
            $display("FAIL nonowner_rsp: v0=%0b res=%0h z=%0b want 1 %0h %0b", rsp0_valid, rsp_result, rsp_zero, e.res, e.zero);
        else n_pass++;
        repeat (4) begin
            @(negedge clk);
            if ({rsp0_valid, rsp1_valid, busy} !== 3'b101) stuck++;
        end
        n_checks++;
        if (stuck != 0) $display("FAIL nonowner_hold: %0d cycles left RESP want 0", stuck);
        else n_pass++;
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL nonowner_release: busy=%0b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        bit got;
        tick();
        drive_req(1, 3'b110, 9, 3);
        @(negedge clk);
        sb.push_back(mk(1, 3'b110, 9, 3));
        tick();
        req1_valid = 0;
        @(negedge clk);
        n_checks++;
        if (alu_alucontrol !== 3'b110 || alu_srca !== W'(9)) $display("FAIL pass_opcode: ctl=%b a=%0h want 110 9", alu_alucontrol, alu_srca);
        else n_pass++;
        wait_rsp(got);
        e = sb.pop_front();
        n_checks++;
        if (!got || {rsp0_valid, rsp1_valid} !== 2'b01 || rsp_zero !== e.zero)
            $display("FAIL pass_rsp: v=%b z=%0b want 01 %0b", {rsp0_valid, rsp1_valid}, rsp_zero, e.zero);
        else n_pass++;
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
    endtask

    task automatic test_drop();
        bit got;
        do_reset();
        req0_valid = 1;          // offered then withdrawn before any rising edge
        @(negedge clk);
        #1 req0_valid = 0;
        tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL drop_state: busy=%0b want 0", busy);
        else n_pass++;
        tick();
        drive_req(0, 3'b011, 3, 4);
        drive_req(1, 3'b101, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL drop_grant: ready=%b want 10", {req0_ready, req1_ready});
        else n_pass++;
        sb.push_back(mk(0, 3'b011, 3, 4));
        tick();
        clear_reqs();
        wait_rsp(got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp0_valid !== 1'b1 || rsp_result !== e.res) $display("FAIL drop_rsp: v0=%0b res=%0h want 1 %0h", rsp0_valid, rsp_result, e.res);
        else n_pass++;
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1;
        rsp0_ready = 0; rsp1_ready = 0;
        clear_reqs();
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_reset_in_resp();
        test_nonowner_ready();
        test_passthrough();
        test_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
